// File: rtl/lfsr_stim_pkg.sv
// Shared types and pure helpers for the LFSR stimulus / MISR signature block.
package lfsr_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
    localparam logic [31:0] DEF_MISR_POLY = 32'hEDB88320;

    // Helpers work on a fixed maximum width; callers zero-extend in and truncate out.
    localparam int unsigned MAX_STATE_W = 64;
    localparam int unsigned MAX_IDX_W   = 6;
    localparam int unsigned MAX_RESP_W  = 256;

    // Right-shifting Galois step; upper bits beyond the caller's width stay zero.
    function automatic logic [MAX_STATE_W-1:0] galois_step(
        input logic [MAX_STATE_W-1:0] s,
        input logic [MAX_STATE_W-1:0] poly
    );
        logic [MAX_STATE_W-1:0] shifted;
        shifted = s >> 1;
        return s[0] ? (shifted ^ poly) : shifted;
    endfunction

    // XOR of all misr_w-wide chunks of the low resp_w bits of r (last chunk zero-padded).
    function automatic logic [MAX_STATE_W-1:0] fold(
        input logic [MAX_RESP_W-1:0] r,
        input int unsigned           resp_w,
        input int unsigned           misr_w
    );
        logic [MAX_STATE_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < MAX_RESP_W; i++) begin
            if (i < resp_w) begin
                acc[MAX_IDX_W'(i % misr_w)] = acc[MAX_IDX_W'(i % misr_w)] ^ r[i];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/lfsr_channel.sv
// One Galois LFSR stimulus channel with a synthesis-time seed.
module lfsr_channel
    import lfsr_stim_pkg::*;
#(
    parameter int unsigned     WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(DEF_LFSR_POLY),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    // Seed on reset or load; load beats step so a restart always lands on the seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (step) begin
            value <= WIDTH'(galois_step(MAX_STATE_W'(value), MAX_STATE_W'(POLY)));
        end
    end

endmodule

// File: rtl/lfsr_stimulus_misr.sv
// Run-controlled LFSR stimulus generator with MISR response compaction.
module lfsr_stimulus_misr
    import lfsr_stim_pkg::*;
#(
    parameter int unsigned           NUM_CH     = 9,
    parameter int unsigned           CH_WIDTH   = 16,
    parameter logic [CH_WIDTH-1:0]   LFSR_POLY  = CH_WIDTH'(DEF_LFSR_POLY),
    parameter int unsigned           SEED_BASE  = 3,
    parameter int unsigned           SEED_STEP  = 2,
    parameter int unsigned           RESP_WIDTH = 64,
    parameter int unsigned           MISR_WIDTH = 32,
    parameter logic [MISR_WIDTH-1:0] MISR_POLY  = MISR_WIDTH'(DEF_MISR_POLY),
    parameter int unsigned           CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         pause,
    input  logic [CNT_WIDTH-1:0]         run_cycles,
    input  logic [RESP_WIDTH-1:0]        resp_in,
    output logic [NUM_CH*CH_WIDTH-1:0]   stim_out,
    output logic                         stim_valid,
    output logic [MISR_WIDTH-1:0]        signature,
    output logic                         busy,
    output logic                         done
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 free_run_q;
    logic                 load_c, step_c;
    logic [MISR_WIDTH-1:0] misr_next_c;

    // Stimulus channels; seeds wrap modulo 2^CH_WIDTH and a zero seed becomes 1.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_WIDTH-1:0] RAW_SEED = CH_WIDTH'(SEED_BASE + SEED_STEP * i);
        localparam logic [CH_WIDTH-1:0] CH_SEED  = (RAW_SEED == '0) ? CH_WIDTH'(1) : RAW_SEED;

        lfsr_channel #(
            .WIDTH (CH_WIDTH),
            .POLY  (LFSR_POLY),
            .SEED  (CH_SEED)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .load  (load_c),
            .step  (step_c),
            .value (stim_out[i*CH_WIDTH +: CH_WIDTH])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and step/load strobes; start overrides pause and the terminal step.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        if (start) begin
            state_d = RUN;
            load_c  = 1'b1;
        end else if (state_q == RUN && !pause) begin
            step_c = 1'b1;
            if (!free_run_q && cnt_q == CNT_WIDTH'(1)) begin
                state_d = DONE;
            end
        end
    end

    // Next MISR value: Galois shift then absorb the folded response.
    always_comb begin
        misr_next_c = MISR_WIDTH'(galois_step(MAX_STATE_W'(signature), MAX_STATE_W'(MISR_POLY)))
                    ^ MISR_WIDTH'(fold(MAX_RESP_W'(resp_in), RESP_WIDTH, MISR_WIDTH));
    end

    // Run-length counter, free-run flag and signature register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            free_run_q <= 1'b0;
            signature  <= '0;
        end else if (load_c) begin
            cnt_q      <= run_cycles;
            free_run_q <= (run_cycles == '0);
            signature  <= '0;
        end else if (step_c) begin
            signature <= misr_next_c;
            if (!free_run_q) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    // Status flags registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
        end
    end

    assign stim_valid = busy && !pause;

endmodule

// File: tb/tb_lfsr_stimulus_misr.sv
// Randomised self-checking bench for lfsr_stimulus_misr against a behavioural model.
module tb_lfsr_stimulus_misr;

    localparam int NCH = 9;
    localparam int CW  = 16;
    localparam int SW  = NCH * CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          pause;
    logic [15:0]   run_cycles;
    logic [63:0]   resp_in;
    logic [SW-1:0] stim_out, stim_out_z;
    logic          stim_valid, stim_valid_z;
    logic [31:0]   signature, signature_z;
    logic          busy, busy_z, done, done_z;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 finished.
    logic [15:0] m_ch [NCH];
    logic [31:0] m_sig;
    int          m_mode;
    int          m_rem;
    bit          m_free;

    always #5 clk = ~clk;

    lfsr_stimulus_misr dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .run_cycles (run_cycles),
        .resp_in    (resp_in),
        .stim_out   (stim_out),
        .stim_valid (stim_valid),
        .signature  (signature),
        .busy       (busy),
        .done       (done)
    );

    lfsr_stimulus_misr #(.SEED_BASE(0), .SEED_STEP(0)) dut_z (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .run_cycles (run_cycles),
        .resp_in    (resp_in),
        .stim_out   (stim_out_z),
        .stim_valid (stim_valid_z),
        .signature  (signature_z),
        .busy       (busy_z),
        .done       (done_z)
    );

    function automatic logic [15:0] seed_of(input int i);
        int v;
        v = (3 + 2 * i) % 65536;
        return (v == 0) ? 16'd1 : 16'(v);
    endfunction

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        if (s % 2 == 1) return (s / 2) ^ 16'hB400;
        return s / 2;
    endfunction

    function automatic logic [31:0] ref_misr(input logic [31:0] m, input logic [63:0] r);
        logic [31:0] nx;
        nx = (m % 2 == 1) ? ((m / 2) ^ 32'hEDB88320) : (m / 2);
        return nx ^ r[31:0] ^ r[63:32];
    endfunction

    function automatic logic [SW-1:0] exp_stim();
        logic [SW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*CW +: CW] = m_ch[i];
        return v;
    endfunction

    function automatic logic [SW-1:0] seed_stim();
        logic [SW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*CW +: CW] = seed_of(i);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_ch[i] = seed_of(i);
        m_sig  = '0;
        m_mode = 0;
        m_rem  = 0;
        m_free = 1'b0;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, drop start.
    task automatic clk_edge();
        @(posedge clk);
        if (start) begin
            for (int i = 0; i < NCH; i++) m_ch[i] = seed_of(i);
            m_sig  = '0;
            m_mode = 1;
            m_rem  = int'(run_cycles);
            m_free = (run_cycles == 0);
        end else if (m_mode == 1 && !pause) begin
            for (int i = 0; i < NCH; i++) m_ch[i] = ref_lfsr(m_ch[i]);
            m_sig = ref_misr(m_sig, resp_in);
            if (!m_free) begin
                m_rem--;
                if (m_rem == 0) m_mode = 2;
            end
        end
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (stim_out[15:0] !== 16'h0003 || stim_out[31:16] !== 16'h0005 || stim_out[143:128] !== 16'h0013) begin
            n_fail++;
            $display("FAIL reset_seeds: got ch0=%h ch1=%h ch8=%h want 0003 0005 0013",
                     stim_out[15:0], stim_out[31:16], stim_out[143:128]);
        end
        n_tests++;
        if ({signature, busy, done, stim_valid} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_status: got sig=%h busy=%b done=%b valid=%b want 0 0 0 0",
                     signature, busy, done, stim_valid);
        end
        #10 reset = 1'b0;
        model_reset();
        clk_edge();
        n_tests++;
        if (stim_out !== exp_stim() || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_static: got stim=%h busy=%b want %h 0", stim_out, busy, exp_stim());
        end
    endtask

    task automatic test_lfsr_sequence();
        logic [15:0] want0 [3] = '{16'h0003, 16'hB401, 16'hEE00};
        pause = 1'b0;
        run_cycles = 16'd4;
        resp_in = 64'd0;
        start = 1'b1;
        clk_edge();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (stim_out[15:0] !== want0[k] || busy !== 1'b1 || stim_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL lfsr_seq_%0d: got ch0=%h busy=%b valid=%b want %h 1 1",
                         k, stim_out[15:0], busy, stim_valid, want0[k]);
            end
            clk_edge();
        end
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL lfsr_early_done: got done=%b want 0", done);
        end
        clk_edge();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (done !== 1'b1 || busy !== 1'b0 || stim_out[15:0] !== 16'h3B80 || stim_out !== exp_stim()) begin
                n_fail++;
                $display("FAIL lfsr_frozen_%0d: got done=%b busy=%b stim=%h want 1 0 %h",
                         k, done, busy, stim_out, exp_stim());
            end
            clk_edge();
        end
    endtask

    task automatic test_misr_known();
        run_cycles = 16'd2;
        resp_in = 64'd1;
        start = 1'b1;
        clk_edge();
        n_tests++;
        if (signature !== 32'h0) begin
            n_fail++;
            $display("FAIL misr_cleared: got %h want 00000000", signature);
        end
        clk_edge();
        n_tests++;
        if (signature !== 32'h00000001) begin
            n_fail++;
            $display("FAIL misr_step1: got %h want 00000001", signature);
        end
        clk_edge();
        n_tests++;
        if (signature !== 32'hEDB88321 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL misr_step2: got %h done=%b want edb88321 1", signature, done);
        end
    endtask

    task automatic test_pause();
        logic [SW-1:0] held_stim;
        logic [31:0]   held_sig;
        int            edges;
        run_cycles = 16'd5;
        start = 1'b1;
        clk_edge();
        edges = 0;
        for (int k = 0; k < 2; k++) begin
            resp_in = {$urandom, $urandom};
            clk_edge();
            edges++;
        end
        held_stim = exp_stim();
        held_sig  = m_sig;
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            resp_in = {$urandom, $urandom};
            #1;
            n_tests++;
            if (stim_valid !== 1'b0 || stim_out !== held_stim || signature !== held_sig) begin
                n_fail++;
                $display("FAIL pause_hold_%0d: got valid=%b stim=%h sig=%h want 0 %h %h",
                         k, stim_valid, stim_out, signature, held_stim, held_sig);
            end
            clk_edge();
            edges++;
        end
        pause = 1'b0;
        while (done !== 1'b1 && edges < 30) begin
            resp_in = {$urandom, $urandom};
            clk_edge();
            edges++;
        end
        n_tests++;
        if (edges !== 8 || signature !== m_sig) begin
            n_fail++;
            $display("FAIL pause_done_delay: got edges=%0d sig=%h want 8 %h", edges, signature, m_sig);
        end
    endtask

    task automatic test_free_run_restart();
        int bad;
        run_cycles = 16'd0;
        start = 1'b1;
        clk_edge();
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            resp_in = {$urandom, $urandom};
            #1;
            n_tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL free_run_%0d: got busy=%b done=%b want 1 0", k, busy, done);
            end
            clk_edge();
        end
        n_tests++;
        if (signature !== m_sig || stim_out !== exp_stim()) begin
            n_fail++;
            $display("FAIL free_run_state: got sig=%h stim=%h want %h %h", signature, stim_out, m_sig, exp_stim());
        end
        start = 1'b1;
        clk_edge();
        n_tests++;
        if (stim_out !== seed_stim() || signature !== 32'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_reload: got stim=%h sig=%h busy=%b want %h 0 1",
                     stim_out, signature, busy, seed_stim());
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 8; r++) begin
            run_cycles = 16'($urandom_range(1, 12));
            start = 1'b1;
            clk_edge();
            for (int k = 0; k < 80; k++) begin
                pause   = ($urandom_range(0, 3) == 0);
                resp_in = {$urandom, $urandom};
                if ($urandom_range(0, 39) == 0) begin
                    start = 1'b1;
                    run_cycles = 16'($urandom_range(1, 12));
                end
                #1;
                n_tests++;
                if (stim_out !== exp_stim() || signature !== m_sig || busy !== (m_mode == 1) ||
                    done !== (m_mode == 2) || stim_valid !== (m_mode == 1 && !pause)) begin
                    n_fail++;
                    $display("FAIL random_%0d_%0d: got stim=%h sig=%h b=%b d=%b v=%b want %h %h mode=%0d",
                             r, k, stim_out, signature, busy, done, stim_valid, exp_stim(), m_sig, m_mode);
                end
                clk_edge();
                if (m_mode == 2 && k > 2) break;
            end
            pause = 1'b0;
        end
    endtask

    task automatic test_zero_seed();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < NCH; i++) begin
            n_tests++;
            if (stim_out_z[i*CW +: CW] !== 16'h0001) begin
                n_fail++;
                $display("FAIL zero_seed_ch%0d: got %h want 0001", i, stim_out_z[i*CW +: CW]);
            end
        end
        run_cycles = 16'd3;
        pause = 1'b0;
        start = 1'b1;
        clk_edge();
        clk_edge();
        n_tests++;
        if (stim_out_z !== {NCH{16'hB400}}) begin
            n_fail++;
            $display("FAIL zero_seed_step: got %h want all b400", stim_out_z);
        end
    endtask

    task automatic test_async_reset();
        run_cycles = 16'd10;
        start = 1'b1;
        clk_edge();
        for (int k = 0; k < 3; k++) begin
            resp_in = {$urandom, $urandom};
            clk_edge();
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (stim_out !== seed_stim() || signature !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || stim_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got stim=%h sig=%h b=%b d=%b v=%b want seeds 0 0 0 0",
                     stim_out, signature, busy, done, stim_valid);
        end
        #1 reset = 1'b0;
        model_reset();
        clk_edge();
        n_tests++;
        if (busy !== 1'b0 || stim_out !== exp_stim()) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b stim=%h want 0 %h", busy, stim_out, exp_stim());
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        pause      = 1'b0;
        run_cycles = 16'd0;
        resp_in    = 64'd0;
        test_reset();
        test_lfsr_sequence();
        test_misr_known();
        test_pause();
        test_free_run_restart();
        test_random_runs();
        test_zero_seed();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_stimulus_misr.md
# lfsr_stimulus_misr

Parametrised stimulus-and-signature block for bitstream-generation wrappers of the VTR benchmarks. It drives NUM_CH independent LFSR channels into a design-under-test's unbound inputs and compacts the DUT's otherwise-unobserved outputs into a MISR signature, so synthesis cannot trim the logic. It is the run-controlled, signature-producing successor to the per-input free-running random number generators: seeds are derived from one base and step, and a run-length counter with start/pause/done control is added.

## Interface
- NUM_CH, 9, number of stimulus channels
- CH_WIDTH, 16, bits per channel; wider DUT inputs use concatenated channels, narrower inputs slice them
- LFSR_POLY, 16'hB400, Galois feedback mask, CH_WIDTH bits
- SEED_BASE, 3, seed of channel 0
- SEED_STEP, 2, seed increment per channel; channel i seed = (SEED_BASE + SEED_STEP*i) mod 2^CH_WIDTH
- RESP_WIDTH, 64, width of DUT response bus
- MISR_WIDTH, 32, signature width
- MISR_POLY, 32'hEDB88320, Galois feedback mask for the MISR
- CNT_WIDTH, 16, run-length counter width
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; no other reset exists
- start  input  1  one-cycle pulse: (re)load seeds, clear MISR, begin run
- pause  input  1  level: freezes stepping and absorption while high in RUN
- run_cycles  input  CNT_WIDTH  absorbed cycles per run, sampled on start; 0 = free-run
- resp_in  input  RESP_WIDTH  DUT outputs to compact
- stim_out  output  NUM_CH*CH_WIDTH  channel i at bits [i*CH_WIDTH +: CH_WIDTH]
- stim_valid  output  1  high when stim_out advances this cycle
- signature  output  MISR_WIDTH  MISR contents
- busy  output  1  state is RUN
- done  output  1  state is DONE

## Operation
- Seeds: any channel seed evaluating to 0 is replaced by 1 (all-zero LFSR locks).
- LFSR step (Galois, right shift): lsb = s[0]; s = s >> 1; if lsb, s ^= LFSR_POLY.
- Fold: resp_in split into MISR_WIDTH chunks from bit 0, last chunk zero-padded, all chunks XORed.
- MISR step: m = galois_step(m, MISR_POLY) ^ fold(resp_in).
- States: IDLE (reset), RUN, DONE.
- IDLE: LFSRs hold seeds, MISR = 0, outputs static. start -> RUN.
- RUN: step condition = !pause. On step: every LFSR steps, MISR absorbs, counter decrements (skipped if free-run). When counter is 1 and a step occurs -> DONE.
- Free-run (run_cycles = 0 at start): never leaves RUN except by start or reset.
- DONE: LFSRs and MISR frozen; signature stable. start -> RUN.
- start in RUN or DONE: restart identical to start from IDLE; start wins over pause and over the terminal step in the same cycle.
- reset at any time: all state to reset values immediately, independent of clk.

## Timing
- Reset values: stim_out = seeds, stim_valid = 0, signature = 0, busy = 0, done = 0, counter = 0, state = IDLE.
- Cycle after start: state RUN, stim_out = seeds, signature = 0, counter = run_cycles.
- stim_valid = busy && !pause, combinational from registered state and the pause input.
- In the k-th stepping RUN cycle (k from 0): stim_out = step^k(seed). The MISR absorbs the resp_in of that cycle. Both update at the cycle's end.
- done rises the cycle after the run_cycles-th step; busy falls in the same cycle.
- DUT pipeline latency between stim_out and resp_in is the integrator's concern; the block adds none.

## Structure
- Package lfsr_stim_pkg: state enum {IDLE, RUN, DONE}, default polynomial constants, Galois step and fold functions parameterised by width.
- Sub-module lfsr_channel (params WIDTH, POLY, SEED; ports clk, reset, load, step, value) is instantiated NUM_CH times in a generate loop.
- FSM, counter and MISR live in the top module.

## Test plan
- Reset with defaults -> channel 0 = 16'h0003, channel 1 = 16'h0005, channel 8 = 16'h0013; signature 0; busy/done 0.
- start, run_cycles = 4, pause 0 -> channel 0 shows 0003, B401, EE00 on successive RUN cycles; done rises the cycle after the 4th step; stim_out then frozen.
- resp_in = 1 for 2 steps (run_cycles = 2) -> signature 32'h00000001 after step 1, 32'hEDB88321 at done.
- pause high for 3 cycles mid-run -> stim_valid 0, stim_out/signature/counter unchanged; done is delayed by exactly 3 cycles.
- run_cycles = 0 -> busy stays 1 for 1000 cycles, done never rises; start mid-run reloads seeds and clears signature next cycle.
- SEED_BASE = 0, SEED_STEP = 0 -> all channels seed 1; async reset asserted mid-RUN between clock edges -> outputs return to reset values before the next edge.
